dlsc_data_packer_n: RTL and testbench
=====================================

# dlsc_data_packer_n

Parametrised byte packer: a command gives a count of narrow input words of 1..BYTES valid bytes each. The block packs those bytes contiguously into full-width output beats, starting at an arbitrary byte-lane offset. It generalises the 32-bit packer to any power-of-two bus width and adds optional per-word byte reversal. It sits between a DMA command/data front end and an AXI write-data channel, where the output strobes drive WSTRB directly.

## Interface
- BYTES, 4, bus width in bytes; power of two, 2..16
- BL, 2, log2(BYTES); width of offset and bpw fields
- WLEN, 12, width of cmd_words
- WORDS_ZERO, 0, when 1, cmd_words is words-1 (0-based)

Ports:
- clk  in  1  clock; one clock domain, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_done  out  1  one-cycle pulse after the final output beat of a command is accepted
- cmd_ready  out  1  command handshake
- cmd_valid  in  1  command handshake
- cmd_offset  in  BL  byte lane of the first packed byte in the first output beat
- cmd_bpw  in  BL  valid bytes per input word, minus 1; valid bytes are in_data low lanes 0..bpw
- cmd_words  in  WLEN  number of input words
- cmd_swap  in  1  reverse byte order within each input word (byte k maps to byte bpw-k)
- in_ready  out  1  input handshake
- in_valid  in  1  input handshake
- in_data  in  8*BYTES  unpacked input word
- out_ready  in  1  output handshake
- out_valid  out  1  output handshake
- out_last  out  1  marks the final beat of a command
- out_data  out  8*BYTES  packed data; disabled lanes are driven 0
- out_strb  out  BYTES  byte enables

## Operation
- Byte stream: bytes of word 0, word 1, and so on, each ordered lane 0..bpw, or bpw..0 when swap=1.
- Bytes are placed in output lanes starting at lane offset.
- Beat count = ceil((offset + words*(bpw+1)) / BYTES).
- A beat is emitted when lane BYTES-1 fills, or when the final byte of the command is placed.
- Strobes:
  - First beat: lanes below offset are 0.
  - Last beat: lanes above the final byte are 0.
  - All other lanes are 1.
  - A single-beat command applies both masks.
- Buffer: holds up to BYTES-1 leftover bytes. If an input word crosses a beat boundary, its overflow bytes stay in the buffer.
- Remainder: if the final word crosses a boundary, a remainder state produces one extra beat with out_last=1. No input is consumed during that beat.
- Command registers:
  - Loaded on cmd_ready && cmd_valid.
  - A word counter decrements per accepted input.
  - The lane pointer advances by bpw+1 modulo BYTES.
  - Registers are held until the last input is accepted and the remainder beat has been issued.
- cmd_words=0 with WORDS_ZERO=0 is illegal; behaviour is unspecified and a bench assertion flags it.
- States: IDLE (no command), ACTIVE (command loaded, consuming input), REM (remainder beat pending).
  - IDLE to ACTIVE: on command accept.
  - ACTIVE to IDLE: when the last word is accepted with no overflow.
  - ACTIVE to REM: when the last word is accepted with overflow.
  - REM to IDLE: when the remainder beat is loaded into the output register.

## Timing
- Reset values:
  - Outputs: out_valid=0, out_last=0, out_data=0, out_strb=0, cmd_done=0, in_ready=0, cmd_ready=1 (from the first cycle after reset).
  - Internal: state is IDLE and the buffer is empty.
- cmd_ready = IDLE. An input can be accepted the cycle after command accept.
- in_ready = ACTIVE && (out_ready || !out_valid). It is combinational from out_ready and out_valid. out_* are registered outputs.
- Latency: one cycle from the accepted input that completes a beat to out_valid=1.
- Throughput: one input per cycle with no output stall. The REM beat costs exactly one extra cycle.
- out_valid/out_data/out_strb/out_last are held stable while out_valid && !out_ready.
- Back-to-back commands: the next command can be accepted the cycle after the block reaches IDLE. The previous command's last beat may still be held in the output register; its output stays valid and ordered.
- cmd_done is asserted in the cycle after out_valid && out_ready && out_last.
- rst mid-operation: all state is cleared on the next edge. Partial beats and buffered bytes are discarded, and no cmd_done is issued.

## Test plan
- BYTES=4, offset 0, bpw 3, words 3, swap 0 -> 3 beats, strb 1111 each; out_last on beat 3; cmd_done one cycle after the beat-3 handshake.
- BYTES=4, offset 1, bpw 0, words 6, bytes 0x11..0x66 -> beat 0x33221100 with strb 1110, then beat 0x00665544 with strb 0111 and last.
- BYTES=4, offset 3, bpw 3, words 1, in 0xDDCCBBAA -> beat 0xAA000000 with strb 1000, then remainder beat 0x00DDCCBB with strb 0111 and last; in_ready=0 during the remainder cycle; cmd_ready waits for REM to exit.
- BYTES=4, offset 0, bpw 1, words 2, swap 1, in 0x0000BBAA then 0x0000DDCC -> single beat 0xCCDDAABB, strb 1111, last.
- BYTES=8, offset 5, bpw 2, words 2 -> beat 1 strb 0xE0, beat 2 strb 0x07 and last. Also hold out_ready=0 for 5 cycles mid-stream -> output held stable, in_ready=0, no byte lost or duplicated.
- Assert rst while in REM with out_valid=1 -> next cycle out_valid=0, cmd_ready=1, no cmd_done; a fresh command then packs correctly.

Source files
------------

// File: rtl/dlsc_data_packer_n.sv
// dlsc_data_packer_n: packs 1..BYTES-byte input words contiguously into
// full-width output beats starting at an arbitrary lane offset, with
// optional per-word byte reversal. Output strobes are AXI WSTRB-ready.
module dlsc_data_packer_n #(
  parameter int unsigned BYTES      = 4,
  parameter int unsigned BL         = 2,
  parameter int unsigned WLEN       = 12,
  parameter int unsigned WORDS_ZERO = 0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               cmd_done,
  output logic               cmd_ready,
  input  logic               cmd_valid,
  input  logic [BL-1:0]      cmd_offset,
  input  logic [BL-1:0]      cmd_bpw,
  input  logic [WLEN-1:0]    cmd_words,
  input  logic               cmd_swap,
  output logic               in_ready,
  input  logic               in_valid,
  input  logic [8*BYTES-1:0] in_data,
  input  logic               out_ready,
  output logic               out_valid,
  output logic               out_last,
  output logic [8*BYTES-1:0] out_data,
  output logic [BYTES-1:0]   out_strb
);

  localparam int unsigned DW = 8 * BYTES;

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_REM} state_t;

  state_t           state_q, state_d;
  logic [WLEN-1:0]  words_q, words_d;
  logic [BL-1:0]    lane_q, lane_d;
  logic [BL-1:0]    bpw_q, bpw_d;
  logic             swap_q, swap_d;
  logic [DW-1:0]    buf_data_q, buf_data_d;
  logic [BYTES-1:0] buf_strb_q, buf_strb_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [DW-1:0]    out_data_q, out_data_d;
  logic [BYTES-1:0] out_strb_q, out_strb_d;
  logic             cmd_done_q, cmd_done_d;

  logic [7:0]         in_bytes_c [BYTES];
  logic [2*DW-1:0]    merge_data_c;
  logic [2*BYTES-1:0] merge_strb_c;
  logic [BL:0]        end_lane_c;
  logic               full_c;
  logic               spill_c;
  logic               last_word_c;
  logic               out_free_c;
  logic               in_fire_c;

  assign end_lane_c  = {1'b0, lane_q} + {1'b0, bpw_q} + (BL+1)'(1);
  assign full_c      = end_lane_c[BL];
  assign spill_c     = full_c && (end_lane_c[BL-1:0] != '0);
  assign last_word_c = (WORDS_ZERO != 0) ? (words_q == '0) : (words_q == WLEN'(1));
  assign out_free_c  = out_ready || !out_valid_q;
  assign in_ready    = (state_q == ST_ACTIVE) && out_free_c;
  assign in_fire_c   = in_ready && in_valid;
  assign cmd_ready   = (state_q == ST_IDLE);

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign out_strb  = out_strb_q;
  assign cmd_done  = cmd_done_q;

  // Overlay the current word onto the leftover bytes in a two-beat window.
  always_comb begin
    logic [BL:0]   rel;
    logic [BL-1:0] src;
    rel = '0;
    src = '0;
    for (int b = 0; b < int'(BYTES); b++) begin
      in_bytes_c[b] = in_data[b*8 +: 8];
    end
    merge_data_c = {{DW{1'b0}}, buf_data_q};
    merge_strb_c = {{BYTES{1'b0}}, buf_strb_q};
    for (int i = 0; i < 2*int'(BYTES); i++) begin
      rel = (BL+1)'(i) - {1'b0, lane_q};
      if (((BL+1)'(i) >= {1'b0, lane_q}) && (rel <= {1'b0, bpw_q})) begin
        src = swap_q ? (bpw_q - rel[BL-1:0]) : rel[BL-1:0];
        merge_data_c[i*8 +: 8] = in_bytes_c[src];
        merge_strb_c[i]        = 1'b1;
      end
    end
  end

  // Next-state and output-register logic.
  always_comb begin
    state_d     = state_q;
    words_d     = words_q;
    lane_d      = lane_q;
    bpw_d       = bpw_q;
    swap_d      = swap_q;
    buf_data_d  = buf_data_q;
    buf_strb_d  = buf_strb_q;
    out_valid_d = out_valid_q && !out_ready;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    out_strb_d  = out_strb_q;
    cmd_done_d  = out_valid_q && out_ready && out_last_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d    = ST_ACTIVE;
          words_d    = cmd_words;
          lane_d     = cmd_offset;
          bpw_d      = cmd_bpw;
          swap_d     = cmd_swap;
          buf_data_d = '0;
          buf_strb_d = '0;
        end
      end
      ST_ACTIVE: begin
        if (in_fire_c) begin
          words_d = words_q - WLEN'(1);
          lane_d  = end_lane_c[BL-1:0];
          if (full_c || last_word_c) begin
            // Low half is a complete (or final) beat; high half is the overflow.
            out_valid_d = 1'b1;
            out_data_d  = merge_data_c[DW-1:0];
            out_strb_d  = merge_strb_c[BYTES-1:0];
            out_last_d  = last_word_c && !spill_c;
            buf_data_d  = merge_data_c[2*DW-1:DW];
            buf_strb_d  = merge_strb_c[2*BYTES-1:BYTES];
          end else begin
            buf_data_d = merge_data_c[DW-1:0];
            buf_strb_d = merge_strb_c[BYTES-1:0];
          end
          if (last_word_c) begin
            state_d = spill_c ? ST_REM : ST_IDLE;
          end
        end
      end
      ST_REM: begin
        if (out_free_c) begin
          out_valid_d = 1'b1;
          out_data_d  = buf_data_q;
          out_strb_d  = buf_strb_q;
          out_last_d  = 1'b1;
          buf_data_d  = '0;
          buf_strb_d  = '0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      words_q     <= '0;
      lane_q      <= '0;
      bpw_q       <= '0;
      swap_q      <= 1'b0;
      buf_data_q  <= '0;
      buf_strb_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_strb_q  <= '0;
      cmd_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      words_q     <= words_d;
      lane_q      <= lane_d;
      bpw_q       <= bpw_d;
      swap_q      <= swap_d;
      buf_data_q  <= buf_data_d;
      buf_strb_q  <= buf_strb_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      out_strb_q  <= out_strb_d;
      cmd_done_q  <= cmd_done_d;
    end
  end

endmodule

// File: tb/tb_dlsc_data_packer_n.sv
// Bench for dlsc_data_packer_n: a 4-byte and an 8-byte instance share the
// stimulus; sel8 picks which one is driven and observed.
module tb_dlsc_data_packer_n;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel8;
  logic        cmd_valid;
  logic [2:0]  cmd_offset;
  logic [2:0]  cmd_bpw;
  logic [11:0] cmd_words;
  logic        cmd_swap;
  logic        in_valid;
  logic [63:0] in_data;
  logic        out_ready;

  logic        d4_cmd_done, d4_cmd_ready, d4_in_ready, d4_out_valid, d4_out_last;
  logic [31:0] d4_out_data;
  logic [3:0]  d4_out_strb;
  logic        d8_cmd_done, d8_cmd_ready, d8_in_ready, d8_out_valid, d8_out_last;
  logic [63:0] d8_out_data;
  logic [7:0]  d8_out_strb;

  logic        o_cmd_done, o_cmd_ready, o_in_ready, o_valid, o_last;
  logic [63:0] o_data;
  logic [7:0]  o_strb;

  int checks   = 0;
  int failures = 0;

  logic [63:0] wq[$];
  logic [63:0] exp_data[$];
  logic [7:0]  exp_strb[$];
  logic        exp_last[$];
  logic [63:0] cap_data[$];
  logic [7:0]  cap_strb[$];

  always #5 clk = ~clk;

  dlsc_data_packer_n #(.BYTES(4), .BL(2), .WLEN(12), .WORDS_ZERO(0)) u_dut4 (
    .clk(clk), .rst(rst),
    .cmd_done(d4_cmd_done), .cmd_ready(d4_cmd_ready), .cmd_valid(cmd_valid && !sel8),
    .cmd_offset(cmd_offset[1:0]), .cmd_bpw(cmd_bpw[1:0]), .cmd_words(cmd_words), .cmd_swap(cmd_swap),
    .in_ready(d4_in_ready), .in_valid(in_valid && !sel8), .in_data(in_data[31:0]),
    .out_ready(out_ready), .out_valid(d4_out_valid), .out_last(d4_out_last),
    .out_data(d4_out_data), .out_strb(d4_out_strb)
  );

  dlsc_data_packer_n #(.BYTES(8), .BL(3), .WLEN(12), .WORDS_ZERO(0)) u_dut8 (
    .clk(clk), .rst(rst),
    .cmd_done(d8_cmd_done), .cmd_ready(d8_cmd_ready), .cmd_valid(cmd_valid && sel8),
    .cmd_offset(cmd_offset), .cmd_bpw(cmd_bpw), .cmd_words(cmd_words), .cmd_swap(cmd_swap),
    .in_ready(d8_in_ready), .in_valid(in_valid && sel8), .in_data(in_data),
    .out_ready(out_ready), .out_valid(d8_out_valid), .out_last(d8_out_last),
    .out_data(d8_out_data), .out_strb(d8_out_strb)
  );

  assign o_cmd_done  = sel8 ? d8_cmd_done  : d4_cmd_done;
  assign o_cmd_ready = sel8 ? d8_cmd_ready : d4_cmd_ready;
  assign o_in_ready  = sel8 ? d8_in_ready  : d4_in_ready;
  assign o_valid     = sel8 ? d8_out_valid : d4_out_valid;
  assign o_last      = sel8 ? d8_out_last  : d4_out_last;
  assign o_data      = sel8 ? d8_out_data  : {32'h0, d4_out_data};
  assign o_strb      = sel8 ? d8_out_strb  : {4'h0, d4_out_strb};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // A zero word count is illegal with WORDS_ZERO=0.
  always @(posedge clk) begin
    if (!rst && cmd_valid && o_cmd_ready) begin
      checks++;
      assert (cmd_words != 12'd0) else begin
        failures++;
        $error("FAIL cmd_words_zero observed=%0d expected=nonzero", cmd_words);
      end
    end
  end

  task automatic fill_random(input int n);
    wq.delete();
    for (int i = 0; i < n; i++) wq.push_back({$urandom(), $urandom()});
  endtask

  // Reference: walk the byte stream lane by lane, cutting a beat at the top
  // lane or at the final byte. Then drive the command and score every cycle.
  task automatic run_cmd(input bit w8, input int off, input int bpw, input int nwords,
                         input bit swp, input int mode);
    int nb, n, pos, lane, src, fed, cyc;
    bit spill, rem, prev_last_fire, out_fire, in_fire, was_last, exp_in_rdy;
    logic [63:0] word, bd;
    logic [7:0]  bs;
    nb = w8 ? 8 : 4;
    n  = bpw + 1;
    exp_data.delete(); exp_strb.delete(); exp_last.delete();
    cap_data.delete(); cap_strb.delete();
    pos = off; bd = '0; bs = '0;
    for (int w = 0; w < nwords; w++) begin
      word = wq[w];
      for (int j = 0; j < n; j++) begin
        src  = swp ? (n - 1 - j) : j;
        lane = pos % nb;
        bd[lane*8 +: 8] = word[src*8 +: 8];
        bs[lane] = 1'b1;
        pos++;
        if (lane == nb - 1 || (w == nwords - 1 && j == n - 1)) begin
          exp_data.push_back(bd);
          exp_strb.push_back(bs);
          exp_last.push_back(w == nwords - 1 && j == n - 1);
          bd = '0; bs = '0;
        end
      end
    end
    spill = (((off + (nwords - 1) * n) % nb) + n) > nb;

    @(negedge clk);
    sel8 = w8; in_valid = 1'b0; out_ready = 1'b1;
    cmd_valid = 1'b1; cmd_offset = 3'(off); cmd_bpw = 3'(bpw);
    cmd_words = 12'(nwords); cmd_swap = swp;
    #1;
    check("cmd_ready_idle", 64'(o_cmd_ready), 64'(1));
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    fed = 0; rem = 1'b0; prev_last_fire = 1'b0; cyc = 0;
    while ((exp_data.size() > 0 || prev_last_fire) && cyc < 400) begin
      in_valid = (fed < nwords) && ((mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1);
      if (fed < nwords) in_data = wq[fed];
      else in_data = {$urandom(), $urandom()};
      case (mode)
        1: out_ready = ($urandom_range(0, 2) != 0);
        2: out_ready = !(cyc >= 1 && cyc <= 5);
        default: out_ready = 1'b1;
      endcase
      #1;
      check("cmd_done", 64'(o_cmd_done), 64'(prev_last_fire));
      exp_in_rdy = (fed < nwords) && (out_ready || !o_valid);
      check("in_ready", 64'(o_in_ready), 64'(exp_in_rdy));
      check("cmd_ready", 64'(o_cmd_ready), 64'(fed == nwords && !rem));
      out_fire = o_valid && out_ready;
      in_fire  = in_valid && o_in_ready;
      was_last = 1'b0;
      if (out_fire) begin
        check("beat_expected", 64'(exp_data.size() > 0), 64'(1));
        if (exp_data.size() > 0) begin
          check("out_data", o_data, exp_data[0]);
          check("out_strb", 64'(o_strb), 64'(exp_strb[0]));
          check("out_last", 64'(o_last), 64'(exp_last[0]));
          was_last = exp_last[0];
          cap_data.push_back(o_data);
          cap_strb.push_back(o_strb);
          void'(exp_data.pop_front()); void'(exp_strb.pop_front()); void'(exp_last.pop_front());
        end
      end
      if (rem && (out_ready || !o_valid)) rem = 1'b0;
      if (in_fire) begin
        fed++;
        if (fed == nwords && spill) rem = 1'b1;
      end
      prev_last_fire = out_fire && was_last;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    check("run_timeout", 64'(cyc < 400), 64'(1));
    in_valid = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; sel8 = 1'b0; cmd_valid = 1'b0; cmd_offset = '0; cmd_bpw = '0;
    cmd_words = 12'd1; cmd_swap = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    // Reset state of both widths.
    check("rst_out_valid", 64'(o_valid), 64'(0));
    check("rst_out_last", 64'(o_last), 64'(0));
    check("rst_out_data", o_data, 64'(0));
    check("rst_out_strb", 64'(o_strb), 64'(0));
    check("rst_cmd_done", 64'(o_cmd_done), 64'(0));
    check("rst_in_ready", 64'(o_in_ready), 64'(0));
    check("rst_cmd_ready", 64'(o_cmd_ready), 64'(1));
    sel8 = 1'b1;
    #1;
    check("rst8_out_valid", 64'(o_valid), 64'(0));
    check("rst8_cmd_ready", 64'(o_cmd_ready), 64'(1));

    // Aligned full words: three full beats.
    fill_random(3);
    run_cmd(1'b0, 0, 3, 3, 1'b0, 0);
    check("t1_beats", 64'(cap_data.size()), 64'(3));
    for (int i = 0; i < 3; i++) check("t1_strb", 64'(cap_strb[i]), 64'(4'hF));

    // Single bytes from lane 1, junk in unused lanes.
    wq.delete();
    wq.push_back(64'hDEADBE11); wq.push_back(64'hDEADBE22); wq.push_back(64'hDEADBE33);
    wq.push_back(64'hDEADBE44); wq.push_back(64'hDEADBE55); wq.push_back(64'hDEADBE66);
    run_cmd(1'b0, 1, 0, 6, 1'b0, 0);
    check("t2_beat0", cap_data[0], 64'h33221100);
    check("t2_strb0", 64'(cap_strb[0]), 64'h0E);
    check("t2_beat1", cap_data[1], 64'h00665544);
    check("t2_strb1", 64'(cap_strb[1]), 64'h07);

    // Offset 3 full word: overflow produces the remainder beat.
    wq.delete(); wq.push_back(64'hDDCCBBAA);
    run_cmd(1'b0, 3, 3, 1, 1'b0, 0);
    check("t3_beat0", cap_data[0], 64'hAA000000);
    check("t3_strb0", 64'(cap_strb[0]), 64'h08);
    check("t3_beat1", cap_data[1], 64'h00DDCCBB);
    check("t3_strb1", 64'(cap_strb[1]), 64'h07);

    // Byte swap within two-byte words.
    wq.delete(); wq.push_back(64'h0000BBAA); wq.push_back(64'h0000DDCC);
    run_cmd(1'b0, 0, 1, 2, 1'b1, 0);
    check("t4_beats", 64'(cap_data.size()), 64'(1));
    check("t4_beat0", cap_data[0], 64'hCCDDAABB);

    // 8-byte bus, offset 5, with a five-cycle output stall.
    fill_random(2);
    run_cmd(1'b1, 5, 2, 2, 1'b0, 2);
    check("t5_strb0", 64'(cap_strb[0]), 64'hE0);
    check("t5_strb1", 64'(cap_strb[1]), 64'h07);

    // Reset while the remainder is pending behind a stalled output.
    @(negedge clk);
    sel8 = 1'b0; out_ready = 1'b0;
    cmd_valid = 1'b1; cmd_offset = 3'd3; cmd_bpw = 3'd3; cmd_words = 12'd1; cmd_swap = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; in_valid = 1'b1; in_data = 64'hDDCCBBAA;
    #1;
    check("t6_in_ready", 64'(o_in_ready), 64'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("t6_rem_valid", 64'(o_valid), 64'(1));
    check("t6_rem_strb", 64'(o_strb), 64'h08);
    check("t6_rem_cmd_ready", 64'(o_cmd_ready), 64'(0));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    #1;
    check("t6_post_valid", 64'(o_valid), 64'(0));
    check("t6_post_cmd_ready", 64'(o_cmd_ready), 64'(1));
    check("t6_post_done", 64'(o_cmd_done), 64'(0));
    @(posedge clk);
    @(negedge clk);
    #1;
    check("t6_post_done2", 64'(o_cmd_done), 64'(0));
    fill_random(3);
    run_cmd(1'b0, 2, 2, 3, 1'b1, 0);

    // Random commands on both widths with random gaps and backpressure.
    for (int t = 0; t < 40; t++) begin
      bit w8;
      int nb;
      w8 = 1'($urandom_range(0, 1));
      nb = w8 ? 8 : 4;
      fill_random(int'($urandom_range(1, 6)));
      run_cmd(w8, int'($urandom_range(0, nb - 1)), int'($urandom_range(0, nb - 1)),
              wq.size(), 1'($urandom_range(0, 1)), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
